csr_dma_slave: RTL and testbench
================================

CSR_DMA_SLAVE -- requirements
Module: csr_dma_slave

Interface
REQ-001 SHALL have parameter MASTER_ADDRESSWIDTH, default 26, master byte-address width.
REQ-002 SHALL have parameter SLAVE_ADDRESSWIDTH, default 4, slave word-address width; must be at least log2(8+BUF_DEPTH).
REQ-003 SHALL have parameter DATAWIDTH, default 32, bus and register width; a multiple of 8.
REQ-004 SHALL have parameter BUF_DEPTH, default 8, local buffer depth in words.
REQ-005 SHALL use these ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- slave_address  in  SLAVE_ADDRESSWIDTH  word address.
- slave_writedata  in  DATAWIDTH  write data.
- slave_byteenable  in  DATAWIDTH/8  byte lanes for writes.
- slave_write / slave_read / slave_chipselect  in  1 each  slave strobes.
- slave_readdata  out  DATAWIDTH  registered read data.
- master_address  out  MASTER_ADDRESSWIDTH  byte address.
- master_writedata  out  DATAWIDTH  write data.
- master_write / master_read  out  1 each  master strobes.
- master_readdata  in  DATAWIDTH  read data.
- master_readdatavalid  in  1  read data valid.
- master_waitrequest  in  1  stall.
- irq  out  1  done interrupt.

Function
REQ-006 SHALL map slave words: 0 CTRL, 1 STATUS, 2 ADDR, 3 LEN, 4-7 reserved, 8 to 8+BUF_DEPTH-1 buffer.
REQ-007 CTRL SHALL be: bit0 START (write-1 pulse, reads 0), bit1 DIR (0 = SDRAM to buffer, 1 = buffer to SDRAM), bit2 IE.
REQ-008 STATUS SHALL be read-only except W1C bits: bit0 BUSY (RO), bit1 DONE (W1C), bit2 ERR (W1C).
REQ-009 A slave write with chipselect SHALL update only the byte lanes selected by byteenable; START, DONE and ERR decode bit0 of lane 0.
REQ-010 A slave read with chipselect SHALL load slave_readdata on the next edge; the value is valid one cycle after the strobe.
REQ-011 A read of a reserved or unmapped address SHALL return 0; a write to one SHALL be ignored.
REQ-012 If write and read assert together, the write SHALL take priority and slave_readdata SHALL hold.
REQ-013 While BUSY, slave writes to ADDR, LEN, DIR and the buffer SHALL be ignored, and a START SHALL be ignored; buffer reads are allowed.
REQ-014 If START is written while idle with LEN=0 or LEN>BUF_DEPTH, ERR SHALL set, no master transaction SHALL occur, and BUSY SHALL stay 0.
REQ-015 The FSM SHALL have states IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
REQ-016 A valid START SHALL, on the next edge, set BUSY, load the word counter to 0 and the address pointer to ADDR, and enter RD_REQ (DIR=0) or WR_REQ (DIR=1).
REQ-017 In RD_REQ, master_read SHALL be 1 with master_address = pointer; on an edge with waitrequest=0 the FSM SHALL go to RD_WAIT.
REQ-018 In RD_WAIT, master_read SHALL be 0; on readdatavalid the word SHALL be stored in buffer[count], count and pointer SHALL increment, and the FSM SHALL go to RD_REQ, or to DONE if count+1 = LEN.
REQ-019 At most one master read SHALL be outstanding.
REQ-020 In WR_REQ, master_write SHALL be 1 with master_writedata = buffer[count]; on waitrequest=0, count and pointer SHALL increment, and the FSM SHALL go to DONE when count+1 = LEN.
REQ-021 Address and data SHALL be held stable while waitrequest=1.
REQ-022 The pointer SHALL increment by DATAWIDTH/8 and SHALL wrap modulo 2^MASTER_ADDRESSWIDTH.
REQ-023 DONE state SHALL last 1 cycle: it sets the DONE bit, clears BUSY, and returns to IDLE.
REQ-024 If a DONE set and a W1C of DONE occur in the same cycle, the set SHALL win.
REQ-025 irq SHALL equal DONE AND IE, registered.

Reset
REQ-026 While reset_n=0 at an edge:
- all CSRs, count, pointer and slave_readdata SHALL be 0.
- master_read and master_write SHALL be 0.
- irq SHALL be 0.
- FSM SHALL be IDLE.
REQ-027 Reset mid-transfer SHALL abort immediately, with no further strobes; buffer contents are undefined.

Verification
REQ-028 Read DMA: ADDR=0x100, LEN=3, DIR=0, IE=1, START; memory returns 0xA0, 0xA1, 0xA2 with waitrequest=1 for 2 cycles on each request -> addresses 0x100, 0x104, 0x108; buffer[0..2]=A0..A2; DONE=1; irq=1.
REQ-029 Write DMA: preload buffer[0..1]=0x11, 0x22, ADDR=0x3FFFFFC, LEN=2, DIR=1 -> master writes 0x11@0x3FFFFFC then 0x22@0x0000000 (wrap); BUSY falls after the second accept.
REQ-030 LEN=0, then separately LEN=BUF_DEPTH+1, each with START -> ERR=1, no master strobes; W1C of ERR -> reads 0.
REQ-031 Write CTRL during BUSY with START=1, and write ADDR=0xFFF -> ignored; ADDR still reads its original value.
REQ-032 Byteenable=0b0010 write of 0xAABBCCDD to ADDR (reset 0) -> ADDR reads 0x0000CC00; a read of address 5 returns 0.
REQ-033 Assert reset_n=0 in RD_WAIT -> next cycle STATUS=0, master_read=0, irq=0; a fresh START then runs correctly.

Source files
------------

// File: rtl/csr_dma_slave.sv
// CSR-programmed DMA engine moving words between a local buffer and a
// master bus; one outstanding master read at a time.
module csr_dma_slave #(
  parameter int MASTER_ADDRESSWIDTH = 26,
  parameter int SLAVE_ADDRESSWIDTH  = 4,
  parameter int DATAWIDTH           = 32,
  parameter int BUF_DEPTH           = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
  input  logic [DATAWIDTH-1:0]           slave_writedata,
  input  logic [DATAWIDTH/8-1:0]         slave_byteenable,
  input  logic                           slave_write,
  input  logic                           slave_read,
  input  logic                           slave_chipselect,
  output logic [DATAWIDTH-1:0]           slave_readdata,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic                           master_write,
  output logic                           master_read,
  input  logic [DATAWIDTH-1:0]           master_readdata,
  input  logic                           master_readdatavalid,
  input  logic                           master_waitrequest,
  output logic                           irq
);
  localparam int MAW = MASTER_ADDRESSWIDTH;
  localparam int SAW = SLAVE_ADDRESSWIDTH;
  localparam int DW  = DATAWIDTH;
  localparam int BW  = DW / 8;
  localparam int IW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW  = IW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            dir_q, ie_q, done_q, err_q;
  logic [DW-1:0]   addr_q, len_q;
  logic [CW-1:0]   count_q;
  logic [MAW-1:0]  ptr_q;
  logic [DW-1:0]   buf_q [BUF_DEPTH];
  logic [DW-1:0]   rd_mux;
  logic [IW-1:0]   buf_idx;

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] o,
    input logic [DW-1:0] n,
    input logic [BW-1:0] be
  );
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < BW; i++)
      if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  logic busy, wr, rd_en;
  logic sel_ctrl, sel_stat, sel_addr, sel_len, sel_buf;
  logic start_wr, len_ok, go, err_set;
  logic rd_accept, wr_accept, last;

  assign busy     = (state_q != S_IDLE);
  assign wr       = slave_chipselect & slave_write;
  assign rd_en    = slave_chipselect & slave_read & ~slave_write;
  assign sel_ctrl = (slave_address == SAW'(0));
  assign sel_stat = (slave_address == SAW'(1));
  assign sel_addr = (slave_address == SAW'(2));
  assign sel_len  = (slave_address == SAW'(3));
  assign sel_buf  = (int'(slave_address) >= 8) &&
                    (int'(slave_address) < 8 + BUF_DEPTH);
  assign buf_idx  = IW'(slave_address - SAW'(8));

  assign start_wr = wr & sel_ctrl & slave_byteenable[0]
                  & slave_writedata[0];
  assign len_ok   = (len_q != '0) && (len_q <= DW'(BUF_DEPTH));
  assign go       = start_wr & ~busy & len_ok;
  assign err_set  = start_wr & ~busy & ~len_ok;

  assign rd_accept = (state_q == S_RD_WAIT) & master_readdatavalid;
  assign wr_accept = (state_q == S_WR_REQ) & ~master_waitrequest;
  assign last      = ((count_q + CW'(1)) == len_q[CW-1:0]);

  assign master_read      = (state_q == S_RD_REQ);
  assign master_write     = (state_q == S_WR_REQ);
  assign master_address   = ptr_q;
  assign master_writedata = buf_q[count_q[IW-1:0]];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (go)
          state_d = slave_writedata[1] ? S_WR_REQ : S_RD_REQ;
      S_RD_REQ:
        if (!master_waitrequest) state_d = S_RD_WAIT;
      S_RD_WAIT:
        if (master_readdatavalid)
          state_d = last ? S_DONE : S_RD_REQ;
      S_WR_REQ:
        if (!master_waitrequest)
          state_d = last ? S_DONE : S_WR_REQ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_ctrl: rd_mux = DW'({ie_q, dir_q, 1'b0});
      sel_stat: rd_mux = DW'({err_q, done_q, busy});
      sel_addr: rd_mux = addr_q;
      sel_len:  rd_mux = len_q;
      sel_buf:  rd_mux = buf_q[buf_idx];
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      dir_q          <= 1'b0;
      ie_q           <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      addr_q         <= '0;
      len_q          <= '0;
      count_q        <= '0;
      ptr_q          <= '0;
      irq            <= 1'b0;
      slave_readdata <= '0;
    end else begin
      state_q <= state_d;
      irq     <= done_q & ie_q;
      if (wr && sel_ctrl && slave_byteenable[0]) begin
        ie_q <= slave_writedata[2];
        if (!busy) dir_q <= slave_writedata[1];
      end
      if (wr && sel_addr && !busy)
        addr_q <= merge(addr_q, slave_writedata, slave_byteenable);
      if (wr && sel_len && !busy)
        len_q <= merge(len_q, slave_writedata, slave_byteenable);
      if (wr && sel_stat && slave_byteenable[0]) begin
        if (slave_writedata[1]) done_q <= 1'b0;
        if (slave_writedata[2]) err_q  <= 1'b0;
      end
      // set after clear so a finishing transfer beats a W1C
      if (err_set) err_q <= 1'b1;
      if (state_q == S_DONE) done_q <= 1'b1;
      if (go) begin
        count_q <= '0;
        ptr_q   <= MAW'(addr_q);
      end else if (rd_accept || wr_accept) begin
        count_q <= count_q + CW'(1);
        ptr_q   <= ptr_q + MAW'(BW);
      end
      if (rd_en) slave_readdata <= rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (wr && sel_buf && !busy)
      buf_q[buf_idx] <= merge(buf_q[buf_idx], slave_writedata,
                              slave_byteenable);
    if (rd_accept)
      buf_q[count_q[IW-1:0]] <= master_readdata;
  end
endmodule

// File: tb/tb_csr_dma_slave.sv
// Directed bench for csr_dma_slave with a small waitstate memory model.
module tb_csr_dma_slave;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  slave_address = '0;
  logic [31:0] slave_writedata = '0;
  logic [3:0]  slave_byteenable = '0;
  logic        slave_write = 1'b0;
  logic        slave_read = 1'b0;
  logic        slave_chipselect = 1'b0;
  logic [31:0] slave_readdata;
  logic [25:0] master_address;
  logic [31:0] master_writedata;
  logic        master_write, master_read;
  logic [31:0] master_readdata = '0;
  logic        master_readdatavalid = 1'b0;
  logic        master_waitrequest;
  logic        irq;

  csr_dma_slave dut (
    .clk(clk), .reset_n(reset_n),
    .slave_address(slave_address),
    .slave_writedata(slave_writedata),
    .slave_byteenable(slave_byteenable),
    .slave_write(slave_write), .slave_read(slave_read),
    .slave_chipselect(slave_chipselect),
    .slave_readdata(slave_readdata),
    .master_address(master_address),
    .master_writedata(master_writedata),
    .master_write(master_write), .master_read(master_read),
    .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  int wait_len = 2;
  int wait_cnt = 0;
  int strobe_cnt = 0;
  int stab_err = 0;
  logic        hold = 1'b0;
  logic [25:0] h_addr = '0;
  logic [31:0] h_data = '0;
  logic [25:0] rd_q[$];
  logic [25:0] wa_q[$];
  logic [31:0] wd_q[$];

  assign master_waitrequest = (wait_cnt < wait_len);

  // memory: word at 0x100+4k returns 0xA0+k
  always @(posedge clk) begin
    if (master_read || master_write) strobe_cnt <= strobe_cnt + 1;
    if (reset_n && hold) begin
      if (!(master_read || master_write) ||
          master_address != h_addr ||
          (master_write && master_writedata != h_data))
        stab_err <= stab_err + 1;
    end
    hold   <= reset_n && (master_read || master_write)
              && master_waitrequest;
    h_addr <= master_address;
    h_data <= master_writedata;
    if (!reset_n) begin
      wait_cnt <= 0;
      master_readdatavalid <= 1'b0;
    end else begin
      master_readdatavalid <= 1'b0;
      if (master_read || master_write) begin
        if (master_waitrequest) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
      end
      if (master_read && !master_waitrequest) begin
        rd_q.push_back(master_address);
        master_readdatavalid <= 1'b1;
        master_readdata <= 32'hA0 +
          ((32'(master_address) - 32'h100) >> 2);
      end
      if (master_write && !master_waitrequest) begin
        wa_q.push_back(master_address);
        wd_q.push_back(master_writedata);
      end
    end
  end

  task automatic csr_write(input logic [3:0] a,
                           input logic [31:0] d,
                           input logic [3:0] be);
    @(negedge clk);
    slave_address = a;
    slave_writedata = d;
    slave_byteenable = be;
    slave_chipselect = 1'b1;
    slave_write = 1'b1;
    @(negedge clk);
    slave_chipselect = 1'b0;
    slave_write = 1'b0;
  endtask

  task automatic csr_read(input logic [3:0] a,
                          output logic [31:0] d);
    @(negedge clk);
    slave_address = a;
    slave_chipselect = 1'b1;
    slave_read = 1'b1;
    @(negedge clk);
    slave_chipselect = 1'b0;
    slave_read = 1'b0;
    d = slave_readdata;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic wait_done();
    logic [31:0] s;
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      csr_read(4'd1, s);
      if (s[1]) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) $display("FAIL done_timeout: got 0 expected 1");
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_readdata", slave_readdata, 32'h0);
    chk("rst_mread", 32'(master_read), 32'h0);
    chk("rst_mwrite", 32'(master_write), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    csr_read(4'd1, d); chk("rst_status", d, 32'h0);
    csr_read(4'd0, d); chk("rst_ctrl", d, 32'h0);
    csr_read(4'd2, d); chk("rst_addr", d, 32'h0);
  endtask

  task automatic test_byteenable();
    logic [31:0] d;
    csr_write(4'd2, 32'hAABBCCDD, 4'b0010);
    csr_read(4'd2, d); chk("be_addr", d, 32'h0000CC00);
    csr_write(4'd5, 32'h12345678, 4'hF);
    csr_read(4'd5, d); chk("reserved_rd", d, 32'h0);
  endtask

  task automatic test_wr_rd_priority();
    logic [31:0] d;
    csr_read(4'd2, d);
    @(negedge clk);
    slave_address = 4'd3;
    slave_writedata = 32'd5;
    slave_byteenable = 4'hF;
    slave_chipselect = 1'b1;
    slave_write = 1'b1;
    slave_read = 1'b1;
    @(negedge clk);
    slave_chipselect = 1'b0;
    slave_write = 1'b0;
    slave_read = 1'b0;
    chk("prio_hold", slave_readdata, 32'h0000CC00);
    csr_read(4'd3, d); chk("prio_len", d, 32'd5);
  endtask

  task automatic test_read_dma();
    logic [31:0] d;
    rd_q.delete();
    wait_len = 2;
    csr_write(4'd2, 32'h100, 4'hF);
    csr_write(4'd3, 32'd3, 4'hF);
    csr_write(4'd0, 32'h5, 4'hF);
    wait_done();
    chk("rd_count", rd_q.size(), 32'd3);
    if (rd_q.size() == 3) begin
      chk("rd_addr0", 32'(rd_q[0]), 32'h100);
      chk("rd_addr1", 32'(rd_q[1]), 32'h104);
      chk("rd_addr2", 32'(rd_q[2]), 32'h108);
    end
    csr_read(4'd8, d);  chk("rd_buf0", d, 32'hA0);
    csr_read(4'd9, d);  chk("rd_buf1", d, 32'hA1);
    csr_read(4'd10, d); chk("rd_buf2", d, 32'hA2);
    csr_read(4'd1, d);  chk("rd_status", d, 32'h2);
    chk("rd_irq", 32'(irq), 32'h1);
  endtask

  task automatic test_write_dma();
    logic [31:0] d;
    wa_q.delete();
    wd_q.delete();
    wait_len = 4;
    csr_write(4'd1, 32'h2, 4'h1);
    csr_write(4'd8, 32'h11, 4'hF);
    csr_write(4'd9, 32'h22, 4'hF);
    csr_write(4'd2, 32'h03FFFFFC, 4'hF);
    csr_write(4'd3, 32'd2, 4'hF);
    csr_write(4'd0, 32'h3, 4'hF);
    csr_read(4'd1, d);  chk("busy_set", d, 32'h1);
    csr_write(4'd0, 32'h1, 4'hF);
    csr_write(4'd2, 32'hFFF, 4'hF);
    csr_write(4'd8, 32'h99, 4'hF);
    wait_done();
    chk("wr_count", wa_q.size(), 32'd2);
    if (wa_q.size() == 2) begin
      chk("wr_addr0", 32'(wa_q[0]), 32'h03FFFFFC);
      chk("wr_data0", wd_q[0], 32'h11);
      chk("wr_addr1", 32'(wa_q[1]), 32'h0);
      chk("wr_data1", wd_q[1], 32'h22);
    end
    csr_read(4'd1, d);  chk("wr_status", d, 32'h2);
    csr_read(4'd2, d);  chk("busy_addr", d, 32'h03FFFFFC);
    csr_read(4'd8, d);  chk("busy_buf", d, 32'h11);
    chk("wr_irq", 32'(irq), 32'h0);
    repeat (10) @(negedge clk);
    chk("busy_no_restart", wa_q.size(), 32'd2);
    wait_len = 2;
  endtask

  task automatic test_len_err();
    logic [31:0] d;
    int sc;
    csr_write(4'd1, 32'h2, 4'h1);
    sc = strobe_cnt;
    csr_write(4'd3, 32'd0, 4'hF);
    csr_write(4'd0, 32'h1, 4'hF);
    csr_read(4'd1, d);  chk("len0_err", d, 32'h4);
    csr_write(4'd1, 32'h4, 4'h1);
    csr_read(4'd1, d);  chk("len0_w1c", d, 32'h0);
    csr_write(4'd3, 32'd9, 4'hF);
    csr_write(4'd0, 32'h1, 4'hF);
    csr_read(4'd1, d);  chk("len9_err", d, 32'h4);
    csr_write(4'd1, 32'h4, 4'h1);
    csr_read(4'd1, d);  chk("len9_w1c", d, 32'h0);
    chk("err_no_strobe", strobe_cnt, sc);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bit ok;
    int sc;
    rd_q.delete();
    csr_write(4'd2, 32'h100, 4'hF);
    csr_write(4'd3, 32'd3, 4'hF);
    csr_write(4'd0, 32'h5, 4'hF);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (master_readdatavalid) begin
        ok = 1;
        break;
      end
    end
    chk("mid_reached_wait", 32'(ok), 32'h1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_mread", 32'(master_read), 32'h0);
    chk("mid_irq", 32'(irq), 32'h0);
    chk("mid_readdata", slave_readdata, 32'h0);
    sc = strobe_cnt;
    repeat (4) @(negedge clk);
    chk("mid_no_strobe", strobe_cnt, sc);
    csr_read(4'd1, d);  chk("mid_status", d, 32'h0);
    csr_read(4'd2, d);  chk("mid_addr", d, 32'h0);
    rd_q.delete();
    csr_write(4'd2, 32'h200, 4'hF);
    csr_write(4'd3, 32'd2, 4'hF);
    csr_write(4'd0, 32'h5, 4'hF);
    wait_done();
    chk("re_count", rd_q.size(), 32'd2);
    if (rd_q.size() == 2) begin
      chk("re_addr0", 32'(rd_q[0]), 32'h200);
      chk("re_addr1", 32'(rd_q[1]), 32'h204);
    end
    csr_read(4'd8, d);  chk("re_buf0", d, 32'hE0);
    csr_read(4'd9, d);  chk("re_buf1", d, 32'hE1);
    chk("re_irq", 32'(irq), 32'h1);
  endtask

  task automatic test_stability();
    chk("hold_stable", stab_err, 32'd0);
  endtask

  initial begin
    test_reset();
    test_byteenable();
    test_wr_rd_priority();
    test_read_dma();
    test_write_dma();
    test_len_err();
    test_reset_mid();
    test_stability();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
